// File: rtl/lcd_text_feeder_pkg.sv
// Shared constants, state encoding and helpers for the LCD text feeder.
// Contents: HD44780 command bytes, DDRAM row base table, control characters,
// feeder FSM state enum, SET_DDRAM command builder.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;

  // Index 0 is row 0 (0x00), index 1 is row 1 (0x40).
  localparam logic [1:0][7:0] LCD_ROW_BASE = {8'h40, 8'h00};

  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_WRAP
  } feeder_state_e;

  // SET_DDRAM command that places the cursor at column 0 of the given row.
  function automatic logic [7:0] ddram_cmd(input logic row);
    return LCD_CMD_SET_DDRAM | LCD_ROW_BASE[row];
  endfunction

endpackage

// File: rtl/lcd_text_feeder_byte_fifo.sv
// Byte FIFO with extra-MSB pointers and a registered occupancy count.
// Ports: clk, rst (async active-high), push_i/din_i write side, pop_i/dout_o
// read side (dout_o shows the head combinationally), flush_i empties the
// FIFO, full_o/empty_o flags, level_o occupancy.
module byte_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned PW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [7:0]    din_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [7:0]    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [PW-1:0] level_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  // Full when the wrap bits differ and the index bits match.
  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o = level_q;

  // Flush overrides any same-cycle push or pop.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_q + PW'(do_push) - PW'(do_pop);
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/lcd_text_feeder.sv
// Character-stream front end for the HD44780-over-I2C LCD driver.
// Buffers ASCII bytes, tracks the cursor on a COLS x ROWS panel and emits
// single LCD transactions (data write, SET_DDRAM, clear) paced by lcd_busy.
// Ports: clk, rst (async active-high); in_valid/in_char/in_ready producer
// handshake; clear_req flush-and-clear pulse; lcd_busy from the driver;
// lcd_req/lcd_rs/lcd_byte transaction to the driver; fifo_level occupancy;
// cursor_col/cursor_row position of the next character.
module lcd_text_feeder
  import lcd_pkg::*;
#(
  parameter  int unsigned COLS       = 16,
  parameter  int unsigned ROWS       = 2,
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  input  logic             clear_req,
  input  logic             lcd_busy,
  output logic             lcd_req,
  output logic             lcd_rs,
  output logic [7:0]       lcd_byte,
  output logic [LVL_W-1:0] fifo_level,
  output logic [COL_W-1:0] cursor_col,
  output logic             cursor_row
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  feeder_state_e    state_q, state_d;
  logic [7:0]       cur_char_q, cur_char_d;
  logic             is_data_q, is_data_d;
  logic             clear_pend_q, clear_pend_d;
  logic             lcd_req_q, lcd_req_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [7:0]       lcd_byte_q, lcd_byte_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             row_q, row_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             is_print;

  // Row advance; a single-row panel always stays on row 0.
  function automatic logic next_row(input logic row);
    return (ROWS == 2) ? ~row : 1'b0;
  endfunction

  // Pushes are refused while a clear is requested or pending.
  assign in_ready  = !rst && !fifo_full && !clear_pend_q && !clear_req;
  assign fifo_push = in_valid && in_ready;
  assign is_print  = (cur_char_q >= CH_PRINT_LO) && (cur_char_q <= CH_PRINT_HI);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (in_char),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_char_q   <= '0;
      is_data_q    <= 1'b0;
      clear_pend_q <= 1'b0;
      lcd_req_q    <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_byte_q   <= '0;
      col_q        <= '0;
      row_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_char_q   <= cur_char_d;
      is_data_q    <= is_data_d;
      clear_pend_q <= clear_pend_d;
      lcd_req_q    <= lcd_req_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_byte_q   <= lcd_byte_d;
      col_q        <= col_d;
      row_q        <= row_d;
    end
  end

  // Next-state, transaction and cursor logic.
  always_comb begin
    state_d      = state_q;
    cur_char_d   = cur_char_q;
    is_data_d    = is_data_q;
    clear_pend_d = clear_pend_q | clear_req;
    lcd_req_d    = 1'b0;
    lcd_rs_d     = lcd_rs_q;
    lcd_byte_d   = lcd_byte_q;
    col_d        = col_q;
    row_d        = row_q;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A pending clear wins over queued characters.
        if (clear_pend_q) begin
          if (!lcd_busy) begin
            fifo_flush   = 1'b1;
            clear_pend_d = 1'b0;
            lcd_rs_d     = 1'b0;
            lcd_byte_d   = LCD_CMD_CLEAR;
            is_data_d    = 1'b0;
            col_d        = '0;
            row_d        = 1'b0;
            state_d      = ST_ISSUE;
          end
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_char_d = fifo_dout;
          state_d    = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // Only enter ISSUE with the driver idle, so a stale busy is never
        // mistaken for acceptance.
        if (!lcd_busy) begin
          state_d   = ST_ISSUE;
          is_data_d = 1'b0;
          if (is_print) begin
            lcd_rs_d   = 1'b1;
            lcd_byte_d = cur_char_q;
            is_data_d  = 1'b1;
          end else if (cur_char_q == CH_LF) begin
            col_d      = '0;
            row_d      = next_row(row_q);
            lcd_rs_d   = 1'b0;
            lcd_byte_d = ddram_cmd(next_row(row_q));
          end else if (cur_char_q == CH_CR) begin
            col_d      = '0;
            lcd_rs_d   = 1'b0;
            lcd_byte_d = ddram_cmd(row_q);
          end else if (cur_char_q == CH_FF) begin
            col_d      = '0;
            row_d      = 1'b0;
            lcd_rs_d   = 1'b0;
            lcd_byte_d = LCD_CMD_CLEAR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_ISSUE: begin
        // Hold the request until the driver answers with busy.
        lcd_req_d = 1'b1;
        if (lcd_req_q && lcd_busy) begin
          lcd_req_d = 1'b0;
          state_d   = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (!lcd_busy) begin
          state_d = ST_IDLE;
          if (is_data_q) begin
            if (col_q == COL_LAST) begin
              col_d   = '0;
              row_d   = next_row(row_q);
              state_d = ST_WRAP;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end

      ST_WRAP: begin
        // Move the hardware cursor to the start of the new row.
        if (!lcd_busy) begin
          lcd_rs_d   = 1'b0;
          lcd_byte_d = ddram_cmd(row_q);
          is_data_d  = 1'b0;
          state_d    = ST_ISSUE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign lcd_req    = lcd_req_q;
  assign lcd_rs     = lcd_rs_q;
  assign lcd_byte   = lcd_byte_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Scoreboard bench for lcd_text_feeder: a reference model turns every
// accepted byte into expected LCD transactions, a monitor checks them.
module tb_lcd_text_feeder;

  localparam int unsigned COLS       = 16;
  localparam int unsigned ROWS       = 2;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned COL_W      = $clog2(COLS);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_char;
  logic             in_ready;
  logic             clear_req;
  logic             lcd_busy;
  logic             lcd_req;
  logic             lcd_rs;
  logic [7:0]       lcd_byte;
  logic [LVL_W-1:0] fifo_level;
  logic [COL_W-1:0] cursor_col;
  logic             cursor_row;

  lcd_text_feeder #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .clear_req  (clear_req),
    .lcd_busy   (lcd_busy),
    .lcd_req    (lcd_req),
    .lcd_rs     (lcd_rs),
    .lcd_byte   (lcd_byte),
    .fifo_level (fifo_level),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic rs; logic [7:0] b; } txn_t;
  txn_t exp_q[$];
  int   m_col = 0;
  int   m_row = 0;

  function automatic logic [7:0] ddram(input int r);
    return 8'h80 | ((r == 1) ? 8'h40 : 8'h00);
  endfunction

  task automatic model_clear();
    exp_q.push_back({1'b0, 8'h01});
    m_col = 0;
    m_row = 0;
  endtask

  task automatic model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_q.push_back({1'b1, c});
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        exp_q.push_back({1'b0, ddram(m_row)});
      end
    end else if (c == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      exp_q.push_back({1'b0, ddram(m_row)});
    end else if (c == 8'h0D) begin
      m_col = 0;
      exp_q.push_back({1'b0, ddram(m_row)});
    end else if (c == 8'h0C) begin
      model_clear();
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && lcd_req && lcd_busy) begin
      txn_t e;
      n_txn++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL txn_unexpected: got rs=%0d byte=0x%0h, expected none", lcd_rs, lcd_byte);
      end else begin
        e = exp_q.pop_front();
        check("txn", {23'd0, lcd_rs, lcd_byte}, {23'd0, e.rs, e.b});
      end
    end
  end

  // ---------------- LCD driver model ----------------
  bit drv_en       = 1'b1;
  bit hold_busy    = 1'b0;
  bit fixed_timing = 1'b0;

  initial begin
    logic       cap_rs;
    logic [7:0] cap_b;
    int         d;
    int         n;
    lcd_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (drv_en && !rst && lcd_req && !lcd_busy) begin
        d = fixed_timing ? 0 : int'($urandom_range(0, 2));
        repeat (d) begin @(posedge clk); #1; end
        lcd_busy = 1'b1;
        cap_rs   = lcd_rs;
        cap_b    = lcd_byte;
        n = fixed_timing ? 5 : int'($urandom_range(1, 4));
        repeat (n) begin @(posedge clk); #1; end
        while (hold_busy) begin @(posedge clk); #1; end
        check("stable_under_busy", {23'd0, lcd_rs, lcd_byte}, {23'd0, cap_rs, cap_b});
        lcd_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int unsigned last_acc_cyc;

  task automatic push(input logic [7:0] c, input int max_cyc, output bit acc);
    acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = c;
    for (int i = 0; i < max_cyc; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        acc = 1'b1;
        model_char(c);
        #1 last_acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_str(input string s);
    bit acc;
    for (int i = 0; i < s.len(); i++) begin
      push(s[i], 200, acc);
      if (!acc) fail("push_accept");
    end
  endtask

  task automatic wait_quiet();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo_level == 0 && !lcd_req && !lcd_busy) break;
    end
    if (k == 3000) fail("wait_quiet");
    repeat (8) @(negedge clk);
  endtask

  task automatic check_cursor(input string name);
    check({name, "_col"}, 32'(cursor_col), 32'(m_col));
    check({name, "_row"}, 32'(cursor_row), 32'(m_row));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    bit          acc;
    int          k;
    int          tx_before;
    int unsigned req_cyc;
    logic [7:0]  other_tbl [6];
    other_tbl[0] = 8'h00; other_tbl[1] = 8'h07; other_tbl[2] = 8'h1B;
    other_tbl[3] = 8'h7F; other_tbl[4] = 8'h80; other_tbl[5] = 8'hFF;

    rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; clear_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_lcd_req", 32'(lcd_req), 0);
    check("rst_lcd_rs", 32'(lcd_rs), 0);
    check("rst_lcd_byte", 32'(lcd_byte), 0);
    check("rst_level", 32'(fifo_level), 0);
    check_cursor("rst_cursor");
    rst = 1'b0;
    #1 check("post_rst_in_ready", 32'(in_ready), 1);

    // "Hi" with a fixed 5-cycle busy and latency measurement.
    fixed_timing = 1'b1;
    push(8'h48, 20, acc);
    check("hi_acc", 32'(acc), 1);
    req_cyc = 0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (lcd_req) begin req_cyc = cyc; break; end
    end
    if (k == 10) fail("first_req");
    else check("req_latency", req_cyc - last_acc_cyc, 3);
    push_str("i");
    wait_quiet();
    fixed_timing = 1'b0;
    check("hi_col", 32'(cursor_col), 2);
    check("hi_row", 32'(cursor_row), 0);

    // Row wrap: CR then 17 'A'.
    push_str("\rAAAAAAAAAAAAAAAAA");
    wait_quiet();
    check("wrap_col", 32'(cursor_col), 1);
    check("wrap_row", 32'(cursor_row), 1);

    // FF, "A\nB", CR on row 1, LF on row 1.
    push_str("\fA\nB");
    wait_quiet();
    check_cursor("lf_cursor");
    push_str("\r");
    wait_quiet();
    check_cursor("cr_row1");
    push_str("\n");
    wait_quiet();
    check_cursor("lf_row1");

    // FIFO full with the driver held busy.
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push(8'h30 + 8'(i), 20, acc);
      check("full_fill_acc", 32'(acc), 1);
    end
    @(negedge clk); #1;
    check("full_in_ready", 32'(in_ready), 0);
    check("full_level", 32'(fifo_level), FIFO_DEPTH);
    push(8'h5A, 3, acc);
    check("full_drop", 32'(acc), 0);
    check("full_level_after_drop", 32'(fifo_level), FIFO_DEPTH);
    hold_busy = 1'b0;
    wait_quiet();
    check_cursor("full_cursor");

    // Clear with one write in flight and five bytes queued.
    hold_busy = 1'b1;
    push(8'h41, 20, acc);
    check("clr_first_acc", 32'(acc), 1);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_char = 8'h41 + 8'(i);
      @(negedge clk);
      in_valid = 1'b0;
    end
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (fifo_level == 5 && lcd_busy) break;
    end
    if (k == 50) fail("clr_setup");
    clear_req = 1'b1;
    #1 check("clr_ready_pulse", 32'(in_ready), 0);
    @(negedge clk);
    clear_req = 1'b0;
    #1 check("clr_ready_pend", 32'(in_ready), 0);
    model_clear();
    hold_busy = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 200) fail("clr_ready_return");
    else begin
      check("clr_level", 32'(fifo_level), 0);
      check("clr_cmd", {23'd0, lcd_rs, lcd_byte}, {23'd0, 1'b0, 8'h01});
    end
    wait_quiet();
    check_cursor("clr_cursor");

    // Randomised stream.
    for (int i = 0; i < 150; i++) begin
      int unsigned r;
      logic [7:0]  c;
      r = $urandom_range(0, 99);
      if (r < 70)      c = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 77) c = 8'h0A;
      else if (r < 84) c = 8'h0D;
      else if (r < 87) c = 8'h0C;
      else             c = other_tbl[$urandom_range(0, 5)];
      push(c, 200, acc);
      if (!acc) fail("rand_accept");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_quiet();
    check_cursor("rand_cursor");

    // Asynchronous reset with a request outstanding.
    drv_en = 1'b0;
    push(8'h58, 20, acc);
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (lcd_req) break;
    end
    check("pre_rst_req", 32'(lcd_req), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", 32'(lcd_req), 0);
    check("async_rst_level", 32'(fifo_level), 0);
    check("async_rst_col", 32'(cursor_col), 0);
    check("async_rst_row", 32'(cursor_row), 0);
    check("async_rst_ready", 32'(in_ready), 0);
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    @(negedge clk);
    rst    = 1'b0;
    drv_en = 1'b1;
    #1 check("rel_rst_ready", 32'(in_ready), 1);
    tx_before = n_txn;
    push(8'h07, 20, acc);
    check("bel_acc", 32'(acc), 1);
    repeat (20) @(negedge clk);
    check("bel_no_txn", 32'(n_txn), 32'(tx_before));
    check("bel_req", 32'(lcd_req), 0);
    check_cursor("bel_cursor");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_text_feeder.md
Name: lcd_text_feeder

Overview:
Character-stream front end for the HD44780-over-I2C LCD driver. Buffers ASCII bytes from a producer (UART, debug logic) in a small FIFO and tracks the cursor on a COLS x ROWS panel. Translates the stream into a sequence of single LCD transactions: data writes, set-DDRAM-address commands and clear-display commands. Sits directly upstream of the LCD driver and paces itself on the driver's busy output.

Parameters:
COLS, 16, visible columns per row; range 1..40.
ROWS, 2, visible rows; 1 or 2.
FIFO_DEPTH, 16, input FIFO entries; power of two, at least 2.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  producer has a byte on in_char.
in_char  in  8  ASCII byte.
in_ready  out  1  byte accepted on a cycle where in_valid && in_ready.
clear_req  in  1  one-cycle pulse: flush the FIFO and clear the display.
lcd_busy  in  1  busy output of the LCD driver.
lcd_req  out  1  transaction request; held until lcd_busy is seen high.
lcd_rs  out  1  0 = command, 1 = character data; stable while lcd_req or lcd_busy is high.
lcd_byte  out  8  command/data byte; stable under the same rule as lcd_rs.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
cursor_col  out  $clog2(COLS)  column of the next character.
cursor_row  out  1  row of the next character.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Outputs: lcd_req=0, lcd_rs=0, lcd_byte=0, in_ready=0 while rst is high and 1 on the first cycle after release, fifo_level=0, cursor 0,0.
  - State: FSM returns to IDLE, FIFO is emptied, any pending clear is dropped.
  - No transaction is issued on reset. Display initialisation belongs to the driver.
- in_ready = !fifo_full && !clear_pend && !clear_req. A push is dropped when in_ready is low.
- clear_req sets clear_pend. IDLE services clear_pend before the FIFO:
  - empty the FIFO;
  - issue command 0x01;
  - reset the cursor to 0,0;
  - clear clear_pend on entering ISSUE.
- clear_req during a transaction in flight: that transaction completes, then the clear is serviced.
- FSM states and transitions:
  - IDLE: if clear_pend, go to ISSUE with the clear. Else if FIFO not empty, pop the head into cur_char and go to DECODE.
  - DECODE: classify cur_char.
    - 0x20..0x7E: lcd_rs=1, lcd_byte=cur_char; go to ISSUE.
    - 0x0A (LF): col=0, row=(row+1) mod ROWS; emit SET_DDRAM for the new row; go to ISSUE.
    - 0x0D (CR): col=0; emit SET_DDRAM for the current row; go to ISSUE.
    - 0x0C (FF): behaves as clear (0x01, cursor 0,0).
    - Any other byte: discarded, back to IDLE, no transaction.
  - ISSUE: lcd_req=1 until lcd_busy samples 1, then drop lcd_req and go to WAIT_DONE.
  - WAIT_DONE: wait for lcd_busy=0.
    - After a data write: col+1. If the new col == COLS, set col=0, row=(row+1) mod ROWS and go to WRAP.
    - Otherwise go to IDLE.
  - WRAP: load SET_DDRAM for the new row; go to ISSUE. On completion, return to IDLE without a further col increment.
- SET_DDRAM byte = 0x80 | row_base; row_base is 0x00 for row 0 and 0x40 for row 1. With ROWS=1, row stays 0.
- Latency: a byte accepted on edge N with the FIFO empty and the FSM in IDLE gives a pop at N+1, DECODE at N+2 and lcd_req high after edge N+3.
- A command byte is never issued while lcd_busy is high at ISSUE entry. ISSUE is entered only from states in which lcd_busy has been observed low.
- FIFO pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - full = MSBs differ and the rest are equal.
  - Push and pop in the same cycle are both legal when not full; the level is unchanged.
- Cursor arithmetic: col compares against COLS-1 before increment. Row is modulo ROWS, so row 1 wraps to row 0 and the panel overwrites; there is no scroll.

Decomposition:
- Package lcd_pkg holds:
  - LCD_CMD_CLEAR=8'h01, LCD_CMD_SET_DDRAM=8'h80;
  - the row base address table {8'h00, 8'h40};
  - the character constants CH_LF, CH_CR, CH_FF;
  - the feeder state enum.
- Sub-module byte_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty/level) holds the FIFO. The FSM and cursor logic stay in lcd_text_feeder.

Test Plan:
- Push "Hi" with lcd_busy returned 1 for 5 cycles per request -> two transactions rs=1: 0x48 then 0x69; cursor 2,0; first lcd_req 3 cycles after acceptance.
- Push 17 'A' with COLS=16 -> 16 data writes, then command 0x C0, then data 0x41; cursor ends at 1,1.
- Push "A\nB" -> 0x41 (rs=1), 0xC0 (rs=0), 0x42 (rs=1); CR on row 1 -> 0xC0; LF on row 1 -> 0x80.
- Hold lcd_busy high, push 16 bytes then a 17th -> the first is popped, so the FIFO takes 17 total before in_ready=0 with fifo_level=16; byte 18 is dropped.
- Pulse clear_req with 5 bytes queued and a transaction in flight -> the in-flight write completes, the FIFO is emptied, then 0x01 (rs=0) is issued and the cursor is 0,0; in_ready stays low until the clear is issued.
- Assert rst while lcd_req=1 -> lcd_req=0 in the same cycle, fifo_level=0, cursor 0,0; push 0x07 after reset -> no transaction.
